parity_gen_check: RTL and testbench
===================================

Name: parity_gen_check

Overview:
Streaming parity generator and checker with a parametrised data width and run-time even/odd selection.
- Generate mode: appends a parity bit above the data MSB.
- Check mode: verifies a received word whose parity bit is its MSB, flags errors and keeps a saturating error count.
- One registered output stage with a valid/ready handshake on both sides. Sits between data producers and serial/link logic that needs parity-protected words.

Parameters:
DATA_W, 8, payload width in bits (>=1); words are DATA_W+1 bits including parity.
CNT_W, 8, width of the error counter (>=1).

Ports:
Clk  input  1  clock; all state changes on rising edge.
Rst_n  input  1  synchronous active-low reset.
Mode_Odd  input  1  0 = even parity, 1 = odd parity; sampled when a word is accepted.
Mode_Check  input  1  0 = generate, 1 = check; sampled when a word is accepted.
In_Valid  input  1  input word valid.
In_Ready  output  1  block can accept a word this cycle.
In_Data  input  DATA_W+1  bit DATA_W is parity in check mode and ignored in generate mode; [DATA_W-1:0] is payload.
Out_Valid  output  1  output word valid.
Out_Ready  input  1  downstream accepts the output word.
Out_Data  output  DATA_W+1  {parity, payload}.
Out_Err  output  1  parity error for the word on Out_Data; always 0 for generate-mode words.
Err_Count  output  CNT_W  number of check-mode errors since reset or clear; saturating.
Err_Clr  input  1  synchronous clear of Err_Count.

Behaviour:
- Reset (Rst_n=0 at a rising edge): Out_Valid=0, Out_Data=0, Out_Err=0, Err_Count=0. Reset overrides every other input. A word held mid-handshake is discarded.
- In_Ready = !Out_Valid || Out_Ready, purely combinational. It must not depend on In_Valid.
- Accept: In_Valid && In_Ready at a rising edge. On acceptance, the output register loads, Out_Valid=1 and latency is 1 cycle.
- Out_Valid stays 1 until Out_Ready=1 at an edge. If no new word is accepted in that same cycle, Out_Valid goes to 0.
- Simultaneous output pop and input accept: the register reloads and Out_Valid stays 1, so full throughput is 1 word per cycle.
- While Out_Valid && !Out_Ready: Out_Data and Out_Err are held stable. Mode input changes do not alter the held word.
- Generate mode:
  - p = (^In_Data[DATA_W-1:0]) ^ Mode_Odd.
  - Out_Data = {p, In_Data[DATA_W-1:0]}; Out_Err = 0.
  - With even parity, the total ones count of Out_Data is even; with odd parity, it is odd.
- Check mode:
  - Out_Data = In_Data unchanged.
  - Out_Err = (^In_Data[DATA_W:0]) ^ Mode_Odd, i.e. 1 when the total ones count mismatches the selected mode.
- Err_Count:
  - Updates at input acceptance, not at output pop.
  - Increments by 1 for each accepted check-mode word with an error.
  - Saturates at all ones and does not wrap.
  - Err_Clr=1 forces it to 0. If Err_Clr and an erroneous accept occur in the same cycle, clear wins and the result is 0.
  - Err_Clr has no effect on Out_Valid, Out_Data or Out_Err.
- In_Valid=1 with In_Ready=0: the word is not taken and no counter change occurs. The producer holds the word until it is accepted.

Test Plan:
- Generate, even, DATA_W=8, Out_Ready=1. Inputs 0xAA, 0xAB, 0x8C on consecutive cycles -> Out_Data 9'h0AA, 9'h1AB, 9'h18C, each 1 cycle after its accept. Out_Err=0 throughout.
- Generate, odd. Inputs 0xAA, 0x00 -> Out_Data 9'h1AA, 9'h100.
- Check, even. Inputs 9'h1AB, 9'h0AB, 9'h000 -> Out_Err 0, 1, 0 and Err_Count ends at 1. Repeat with Mode_Odd=1 on 9'h0AB -> Out_Err 0.
- Backpressure:
  - Accept 0x55; hold Out_Ready=0 for 3 cycles while In_Valid=1 with 0x0F -> In_Ready=0 and Out_Data stays 9'h055.
  - Raise Out_Ready -> next edge Out_Data=9'h10F and Out_Valid stays 1.
- Counter, with CNT_W=2:
  - Six erroneous check words -> Err_Count sequence 1, 2, 3, 3, 3, 3.
  - Err_Clr asserted in the same cycle as an erroneous accept -> Err_Count=0.
- Reset mid-operation: Out_Valid=1, Out_Ready=0, Err_Count=2, then Rst_n=0 for 1 cycle -> Out_Valid=0, Out_Data=0, Out_Err=0, Err_Count=0 and In_Ready=1 after the edge.

Source files
------------

// File: rtl/parity_gen_check.sv
// Streaming even/odd parity generator and checker.
// One registered valid/ready stage plus a saturating error counter.
module parity_gen_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Mode_Odd,
  input  logic              Mode_Check,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W:0]   In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W:0]   Out_Data,
  output logic              Out_Err,
  output logic [CNT_W-1:0]  Err_Count,
  input  logic              Err_Clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            accept;
  logic            gen_par;
  logic            chk_err;
  logic [DATA_W:0] nxt_data;
  logic            nxt_err;

  assign In_Ready = !Out_Valid || Out_Ready;
  assign accept   = In_Valid && In_Ready;

  assign gen_par = (^In_Data[DATA_W-1:0]) ^ Mode_Odd;
  assign chk_err = (^In_Data) ^ Mode_Odd;

  always_comb begin
    nxt_data = {gen_par, In_Data[DATA_W-1:0]};
    nxt_err  = 1'b0;
    unique case (1'b1)
      Mode_Check: begin
        nxt_data = In_Data;
        nxt_err  = chk_err;
      end
      default: ;
    endcase
  end

  // A pop without a fresh accept empties the stage.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Err   <= 1'b0;
    end else if (accept) begin
      Out_Valid <= 1'b1;
      Out_Data  <= nxt_data;
      Out_Err   <= nxt_err;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n || Err_Clr) begin
      Err_Count <= '0;
    end else if (accept && nxt_err
                 && Err_Count != CNT_MAX) begin
      Err_Count <= Err_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_gen_check.sv
// Scoreboard bench for parity_gen_check.
// Reference model derives parity from ones counts.
module tb_parity_gen_check;

  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Mode_Odd = 1'b0;
  logic          Mode_Check = 1'b0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [DW:0]   In_Data = '0;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [DW:0]   Out_Data;
  logic          Out_Err;
  logic [CW-1:0] Err_Count;
  logic          Err_Clr = 1'b0;

  logic dir_rdy = 1'b0;
  logic rnd_rdy = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   mon_en = 1'b0;

  assign Out_Ready = rand_rdy ? rnd_rdy : dir_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;

  parity_gen_check #(.DATA_W(DW), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Mode_Odd   (Mode_Odd),
    .Mode_Check (Mode_Check),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Data    (In_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Data   (Out_Data),
    .Out_Err    (Out_Err),
    .Err_Count  (Err_Count),
    .Err_Clr    (Err_Clr)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t ref_out(logic [DW:0] d,
                                   bit odd, bit chk);
    exp_t r;
    int   ones;
    if (!chk) begin
      ones = $countones(d[DW-1:0]) + int'(odd);
      r.d  = {1'(ones % 2), d[DW-1:0]};
      r.e  = 1'b0;
    end else begin
      ones = $countones(d);
      r.d  = d;
      r.e  = ((ones % 2) != int'(odd));
    end
    return r;
  endfunction

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: decides acceptance and queues expectations.
  always @(posedge Clk) begin
    exp_t x;
    if (!Rst_n) begin
      q.delete();
      cnt = 0;
    end else begin
      if (In_Valid && (q.size() == 0 || Out_Ready)) begin
        x = ref_out(In_Data, Mode_Odd, Mode_Check);
        q.push_back(x);
        if (x.e && cnt < MAXC) cnt = cnt + 1;
      end
      if (Err_Clr) cnt = 0;
    end
  end

  // Monitor: compares whenever a word is presented.
  always @(negedge Clk) begin
    if (mon_en && Rst_n) begin
      cmp("in_ready", 32'(In_Ready),
          32'(q.size() == 0 || Out_Ready));
      cmp("out_valid", 32'(Out_Valid), 32'(q.size() != 0));
      cmp("err_count", 32'(Err_Count), 32'(cnt));
      if (q.size() != 0) begin
        cmp("out_data", 32'(Out_Data), 32'(q[0].d));
        cmp("out_err", 32'(Out_Err), 32'(q[0].e));
        if (Out_Ready) void'(q.pop_front());
      end
    end
  end

  always begin
    @(posedge Clk);
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic send(logic [DW:0] d, bit odd, bit chk,
                      bit clr = 1'b0);
    int w = 0;
    In_Valid   = 1'b1;
    In_Data    = d;
    Mode_Odd   = odd;
    Mode_Check = chk;
    Err_Clr    = clr;
    @(negedge Clk);
    while (!In_Ready && w < 50) begin
      w++;
      @(negedge Clk);
    end
    if (w >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got stalled expected accept");
    end
    @(posedge Clk);
    #1;
    Err_Clr = 1'b0;
  endtask

  task automatic idle(int n);
    In_Valid = 1'b0;
    In_Data  = 9'($urandom);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear();
    In_Valid = 1'b0;
    Err_Clr  = 1'b1;
    @(posedge Clk);
    #1;
    Err_Clr = 1'b0;
  endtask

  initial begin
    int w;
    repeat (2) @(posedge Clk);
    #1;
    cmp("rst_valid", 32'(Out_Valid), 0);
    cmp("rst_data", 32'(Out_Data), 0);
    cmp("rst_err", 32'(Out_Err), 0);
    cmp("rst_count", 32'(Err_Count), 0);
    cmp("rst_ready", 32'(In_Ready), 1);
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    dir_rdy = 1'b1;
    send(9'h0AA, 0, 0);
    send(9'h0AB, 0, 0);
    send(9'h08C, 0, 0);
    idle(2);
    send(9'h0AA, 1, 0);
    send(9'h000, 1, 0);
    idle(1);

    clear();
    send(9'h1AB, 0, 1);
    send(9'h0AB, 0, 1);
    send(9'h000, 0, 1);
    idle(1);
    cmp("check_count", 32'(Err_Count), 1);
    send(9'h0AB, 1, 1);
    idle(1);

    dir_rdy = 1'b0;
    send(9'h055, 0, 0);
    In_Data  = 9'h00F;
    Mode_Odd = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      cmp("bp_ready", 32'(In_Ready), 0);
      cmp("bp_hold", 32'(Out_Data), 32'h055);
    end
    @(posedge Clk);
    #1;
    dir_rdy = 1'b1;
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    @(negedge Clk);
    cmp("bp_next", 32'(Out_Data), 32'h10F);
    cmp("bp_valid", 32'(Out_Valid), 1);
    @(posedge Clk);
    #1;

    clear();
    for (int i = 0; i < 6; i++) begin
      send(9'h001, 0, 1);
      cmp("sat_seq", 32'(Err_Count),
          32'((i + 1 > MAXC) ? MAXC : i + 1));
    end
    send(9'h001, 0, 1, 1'b1);
    cmp("clr_wins", 32'(Err_Count), 0);
    idle(1);

    clear();
    send(9'h001, 0, 1);
    send(9'h007, 0, 1);
    dir_rdy  = 1'b0;
    In_Valid = 1'b0;
    @(negedge Clk);
    cmp("pre_rst_cnt", 32'(Err_Count), 2);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    cmp("mid_rst_valid", 32'(Out_Valid), 0);
    cmp("mid_rst_data", 32'(Out_Data), 0);
    cmp("mid_rst_err", 32'(Out_Err), 0);
    cmp("mid_rst_cnt", 32'(Err_Count), 0);
    cmp("mid_rst_ready", 32'(In_Ready), 1);
    Rst_n = 1'b1;
    idle(1);

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(9'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    In_Valid = 1'b0;
    rand_rdy = 1'b0;
    idle(1);
    dir_rdy = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 20) begin
      w++;
      idle(1);
    end
    cmp("drain", 32'(q.size()), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
